// File: rtl/flag_branch_unit.sv
// Purpose: Z/V/N flag register, branch-condition evaluation and flag-hazard stall with a stall counter.
// Latency: flags are visible one cycle after the EX cycle that writes them; branch_taken and flag_stall are combinational.
// Backpressure: ex_stall/ex_flush gate flag writes; flag_stall holds ID/IF while an EX flag writer is in flight.
module flag_branch_unit #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic              ex_flush,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              adder_ovfl,
    input  logic              zero_en,
    input  logic              ovfl_en,
    input  logic              neg_en,
    input  logic              id_branch,
    input  logic [2:0]        id_cond,
    input  logic              cnt_clr,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic              branch_taken,
    output logic              flag_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Branch condition codes
    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A real, unfrozen, unsquashed EX instruction commits its enabled flags
    logic upd;
    logic any_en;
    logic res_zero;

    assign upd      = ex_valid & ~ex_stall & ~ex_flush;
    assign any_en   = zero_en | ovfl_en | neg_en;
    assign res_zero = (alu_out == '0);

    // Committed flags: each flag written independently under its own enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else if (upd) begin
            if (zero_en) flag_z <= res_zero;
            if (ovfl_en) flag_v <= adder_ovfl;
            if (neg_en)  flag_n <= alu_out[DATA_W-1];
        end
    end

    // Branch condition against committed flags; an in-flight writer is covered by flag_stall
    always_comb begin
        branch_taken = 1'b0;
        if (id_branch) begin
            case (id_cond)
                CC_NE:   branch_taken = ~flag_z;
                CC_EQ:   branch_taken = flag_z;
                CC_GT:   branch_taken = ~flag_z & ~flag_n;
                CC_LT:   branch_taken = flag_n;
                CC_GE:   branch_taken = flag_z | (~flag_z & ~flag_n);
                CC_LE:   branch_taken = flag_n | flag_z;
                CC_OV:   branch_taken = flag_v;
                CC_AL:   branch_taken = 1'b1;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    // Conservative hazard: any flag write in EX stalls a conditional branch in ID,
    // even if the condition does not read that flag. Squashed writers never stall.
    assign flag_stall = id_branch & (id_cond != CC_AL) & ex_valid & ~ex_flush & any_en;

    // Saturating count of stall cycles; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (flag_stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit (DATA_W=16, CNT_W=4).
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
// Expected values are hand-computed constants.
module tb_flag_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_stall;
    logic        ex_flush;
    logic [15:0] alu_out;
    logic        adder_ovfl;
    logic        zero_en;
    logic        ovfl_en;
    logic        neg_en;
    logic        id_branch;
    logic [2:0]  id_cond;
    logic        cnt_clr;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        branch_taken;
    logic        flag_stall;
    logic [3:0]  stall_cnt;

    int n_vec;
    int n_err;

    flag_branch_unit #(.DATA_W(16), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_stall     (ex_stall),
        .ex_flush     (ex_flush),
        .alu_out      (alu_out),
        .adder_ovfl   (adder_ovfl),
        .zero_en      (zero_en),
        .ovfl_en      (ovfl_en),
        .neg_en       (neg_en),
        .id_branch    (id_branch),
        .id_cond      (id_cond),
        .cnt_clr      (cnt_clr),
        .flag_z       (flag_z),
        .flag_v       (flag_v),
        .flag_n       (flag_n),
        .branch_taken (branch_taken),
        .flag_stall   (flag_stall),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one EX instruction
    task automatic ex_op(input logic v, input logic [15:0] res, input logic ov,
                         input logic ze, input logic oe, input logic ne);
        ex_valid   = v;
        alu_out    = res;
        adder_ovfl = ov;
        zero_en    = ze;
        ovfl_en    = oe;
        neg_en     = ne;
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] znv);
        chk(tag, {29'd0, flag_z, flag_n, flag_v}, {29'd0, znv});
    endtask

    // Per-ccc expected branch_taken for the four sweep states, bit i = ccc i
    logic [7:0] exp_tbl [4];
    logic [2:0] state_tbl [4];
    logic [15:0] res_tbl [4];
    logic        ov_tbl [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        state_tbl[0] = 3'b100; res_tbl[0] = 16'h0000; ov_tbl[0] = 1'b0; exp_tbl[0] = 8'hB2;
        state_tbl[1] = 3'b010; res_tbl[1] = 16'h8000; ov_tbl[1] = 1'b0; exp_tbl[1] = 8'hA9;
        state_tbl[2] = 3'b001; res_tbl[2] = 16'h0001; ov_tbl[2] = 1'b1; exp_tbl[2] = 8'hD5;
        state_tbl[3] = 3'b000; res_tbl[3] = 16'h0001; ov_tbl[3] = 1'b0; exp_tbl[3] = 8'h95;

        rst_n     = 1'b0;
        ex_stall  = 1'b0;
        ex_flush  = 1'b0;
        id_branch = 1'b0;
        id_cond   = 3'b000;
        cnt_clr   = 1'b0;
        ex_op(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk_flags("reset_flags", 3'b000);
        chk("reset_cnt", {28'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // SUB with zero result, all enables
        ex_op(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk_flags("upd_before_edge", 3'b000);
        tick();
        chk_flags("upd_sub_zero", 3'b100);

        // XOR with 8000, zero_en only: N must stay 0
        ex_op(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("upd_xor_zonly", 3'b000);

        // Gating: flush, stall, and invalid must all block a Z write
        ex_op(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        ex_flush = 1'b1;
        tick();
        chk_flags("gate_flush", 3'b000);
        ex_flush = 1'b0;
        ex_stall = 1'b1;
        tick();
        chk_flags("gate_stall", 3'b000);
        ex_stall = 1'b0;
        ex_valid = 1'b0;
        tick();
        chk_flags("gate_invalid", 3'b000);
        chk("no_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        // Condition sweep over four flag states
        for (int s = 0; s < 4; s++) begin
            id_branch = 1'b0;
            ex_op(1'b1, res_tbl[s], ov_tbl[s], 1'b1, 1'b1, 1'b1);
            tick();
            ex_op(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_flags($sformatf("sweep_state%0d", s), state_tbl[s]);
            id_cond = 3'b111;
            #1;
            chk($sformatf("no_branch_s%0d", s), {31'd0, branch_taken}, 32'd0);
            id_branch = 1'b1;
            for (int c = 0; c < 8; c++) begin
                id_cond = c[2:0];
                #1;
                chk($sformatf("cond_s%0d_c%0d", s, c), {31'd0, branch_taken}, {31'd0, exp_tbl[s][c]});
                chk($sformatf("nostall_s%0d_c%0d", s, c), {31'd0, flag_stall}, 32'd0);
            end
            tick();
        end
        chk("sweep_cnt", {28'd0, stall_cnt}, 32'd0);

        // Hazard: flags are 000; ADD with zero result in EX, EQ branch in ID
        ex_op(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        id_branch = 1'b1;
        id_cond   = 3'b001;
        #1;
        chk("haz_stall", {31'd0, flag_stall}, 32'd1);
        chk("haz_old_flags", {31'd0, branch_taken}, 32'd0);
        id_cond = 3'b111;
        #1;
        chk("haz_al_nostall", {31'd0, flag_stall}, 32'd0);
        id_cond = 3'b001;
        tick();
        ex_op(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("haz_stall_drop", {31'd0, flag_stall}, 32'd0);
        chk("haz_new_z", {31'd0, branch_taken}, 32'd1);
        chk("haz_cnt1", {28'd0, stall_cnt}, 32'd1);

        // Frozen writer: stall persists, flags hold
        ex_op(1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
        ex_stall = 1'b1;
        id_cond  = 3'b000;
        #1;
        chk("frozen_stall", {31'd0, flag_stall}, 32'd1);
        tick();
        chk_flags("frozen_hold", 3'b100);
        chk("frozen_stall2", {31'd0, flag_stall}, 32'd1);
        chk("frozen_cnt2", {28'd0, stall_cnt}, 32'd2);
        ex_flush = 1'b1;
        #1;
        chk("flush_nostall", {31'd0, flag_stall}, 32'd0);
        ex_flush = 1'b0;

        // Counter saturation: 20 stall cycles from 2 must stop at F
        for (int i = 0; i < 20; i++) tick();
        chk("cnt_sat", {28'd0, stall_cnt}, 32'hF);
        cnt_clr = 1'b1;
        tick();
        chk("cnt_clr_wins", {28'd0, stall_cnt}, 32'd0);
        cnt_clr = 1'b0;
        tick();
        chk("cnt_resume", {28'd0, stall_cnt}, 32'd1);

        // Set N=1,V=1 then assert reset mid-cycle with a pending update
        ex_stall = 1'b0;
        ex_op(1'b1, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk_flags("pre_reset_flags", 3'b011);
        ex_op(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_flags("async_reset_flags", 3'b000);
        chk("async_reset_cnt", {28'd0, stall_cnt}, 32'd0);
        tick();
        chk_flags("reset_held_flags", 3'b000);
        chk("reset_held_cnt", {28'd0, stall_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
